ubit_stream_gen: RTL and testbench
==================================

Name: ubit_stream_gen

Overview:
- Upstream stimulus stage for the unary multiplier.
- Converts a BITWIDTH-bit binary operand into a deterministic rate-coded unary bitstream, one bit per enabled cycle, over a window of 2^BITWIDTH bits.
- Bit i is 1 when the loaded value is greater than the bit-reversed index i (a low-discrepancy sequence), so a full window contains exactly the loaded value's number of ones.
- Start/done control lets a controller sequence stream windows to the multiplier's A input.

Parameters:
BITWIDTH, 8, operand width; stream window = 2^BITWIDTH bits

Ports:
iClk  input  1  clock, rising edge
iRst  input  1  synchronous active-high reset
iData  input  BITWIDTH  binary operand to encode
iLoad  input  1  latch iData into operand register
iStart  input  1  begin a new stream window
iEn  input  1  advance stream by one bit when high (RUN only)
iClr  input  1  synchronous abort: return to IDLE, operand retained
oBit  output  1  current unary stream bit
oValid  output  1  oBit is a new stream bit this cycle
oBusy  output  1  high while in RUN
oDone  output  1  high while in DONE
oOnes  output  BITWIDTH  running count of ones emitted in current window

Behaviour:
- Reset (iRst sampled high):
  - state=IDLE; opReg=0; cnt=0.
  - oBit=0, oValid=0, oBusy=0, oDone=0, oOnes=0.
- All outputs are registered.
- Priority: iRst > iClr > iStart > iLoad > iEn.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE:
  - iLoad -> opReg<=iData.
  - iStart -> state RUN, cnt<=0, oOnes<=0, oDone<=0, oValid<=0.
  - iLoad and iStart in the same cycle -> both take effect; the window uses the new iData.
- RUN:
  - iLoad and iStart are ignored; opReg is frozen for the whole window.
  - iEn=1 at an edge:
    - oBit<=(opReg > bitrev(cnt)), unsigned, BITWIDTH bits; bitrev maps cnt bit j to bit BITWIDTH-1-j.
    - oValid<=1.
    - oOnes<=oOnes+that bit.
    - cnt<=cnt+1.
  - iEn=0 at an edge: oValid<=0; cnt, oBit and oOnes hold (pause, no bit lost).
  - Edge with iEn=1 and cnt==2^BITWIDTH-1:
    - The last bit is emitted (oValid=1).
    - state<=DONE; oDone<=1 and oBusy<=0 at that same edge.
    - cnt wraps to 0.
- DONE:
  - oValid<=0 on the next edge.
  - oBit and oOnes hold; oOnes equals opReg.
  - Remains in DONE until iStart, iClr or iRst.
- Latency: iStart sampled at edge k -> RUN from edge k. The first oValid appears after edge k+1 if iEn=1.
- A window with iEn held high takes 2^BITWIDTH+1 cycles from iStart to the last bit.
- iClr in any state:
  - state<=IDLE, cnt<=0.
  - oValid, oBusy and oDone <= 0; oOnes<=0; oBit<=0.
  - opReg retained.
- iRst mid-RUN: identical to power-on reset, including opReg<=0.
- Boundary cases:
  - opReg=0 -> all bits 0.
  - opReg=2^BITWIDTH-1 -> every bit 1 except where bitrev(cnt)=2^BITWIDTH-1 (cnt=2^BITWIDTH-1).
  - oOnes never exceeds 2^BITWIDTH-1, so no overflow.

Test Plan:
1. BITWIDTH=8; reset 2 cycles; iData=128, iLoad 1 cycle; iStart 1 cycle; iEn high -> bits alternate 1,0,1,0... from the first oValid; 256 valid bits; oOnes=128 and oDone=1 at the last-bit edge; oValid=0 the next cycle.
2. iData=0 then iData=255, each with a full window -> 0 ones / 255 ones; for 255, only the final bit (cnt=255) is 0; oOnes=0 / 255.
3. iData=134, iEn toggled 1,0 every cycle during RUN -> 256 valid bits over ~512 cycles; oBit/oOnes hold while iEn=0; total oOnes=134.
4. Mid-RUN (after 100 bits) drive iLoad with iData=10 and iStart -> both ignored; window completes with oOnes = original operand (134).
5. Mid-RUN iClr -> next edge oBusy=0, oValid=0, oOnes=0; a new iStart without iLoad replays the window for the retained operand from bit 0.
6. Mid-RUN iRst -> all outputs 0, opReg=0; iStart without iLoad -> full window of zeros, oOnes=0, oDone=1.

Source files
------------

// File: rtl/ubit_stream_gen.sv
// ubit_stream_gen: converts a BITWIDTH-bit operand into a rate-coded unary
// bitstream over a window of 2^BITWIDTH bits. Bit i is 1 when the operand is
// greater than the bit-reversed index i, so a full window holds exactly
// `operand` ones.
// Ports:
//   iClk, iRst    clock (rising edge), synchronous active-high reset
//   iData, iLoad  operand and its load strobe (honoured in IDLE/DONE only)
//   iStart        begin a new window (honoured in IDLE/DONE only)
//   iEn           advance the stream by one bit while in RUN
//   iClr          synchronous abort to IDLE; the operand is kept
//   oBit, oValid  current stream bit and its new-bit-this-cycle flag
//   oBusy, oDone  high in RUN / high in DONE
//   oOnes         running count of ones emitted in the current window
module ubit_stream_gen #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [BITWIDTH-1:0] iData,
  input  logic                iLoad,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iClr,
  output logic                oBit,
  output logic                oValid,
  output logic                oBusy,
  output logic                oDone,
  output logic [BITWIDTH-1:0] oOnes
);

  localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] op_q, op_d;
  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic [BITWIDTH-1:0] ones_q, ones_d;
  logic                bit_q, bit_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BITWIDTH-1:0] cnt_rev;
  logic                stream_bit;

  // Bit-reversed window index gives the low-discrepancy threshold sequence.
  for (genvar j = 0; j < BITWIDTH; j++) begin : g_rev
    assign cnt_rev[j] = cnt_q[BITWIDTH-1-j];
  end

  assign stream_bit = (op_q > cnt_rev);

  // Next-state and next-output logic; priority iClr > iStart > iLoad > iEn.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;

    if (iClr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ones_d  = '0;
      bit_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (iLoad) op_d = iData;
          if (iStart) begin
            state_d = S_RUN;
            cnt_d   = '0;
            ones_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        S_RUN: begin
          // Operand frozen for the whole window; iEn low pauses without loss.
          if (iEn) begin
            bit_d   = stream_bit;
            valid_d = 1'b1;
            ones_d  = ones_q + BITWIDTH'(stream_bit);
            cnt_d   = cnt_q + BITWIDTH'(1);
            if (cnt_q == CNT_MAX) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oBit   = bit_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oOnes  = ones_q;

endmodule

// File: tb/tb_ubit_stream_gen.sv
// Testbench for ubit_stream_gen: directed windows, expected stream bits queued
// per window and compared by a monitor whenever oValid is high.
module tb_ubit_stream_gen;

  localparam int unsigned BW  = 8;
  localparam int unsigned WIN = 256;

  logic          clk = 1'b0;
  logic          rst, load, start, en, clr;
  logic [BW-1:0] data;
  logic          o_bit, o_valid, o_busy, o_done;
  logic [BW-1:0] o_ones;

  typedef struct packed {
    logic          b;
    logic [BW-1:0] ones;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ubit_stream_gen #(.BITWIDTH(BW)) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iData (data),
    .iLoad (load),
    .iStart(start),
    .iEn   (en),
    .iClr  (clr),
    .oBit  (o_bit),
    .oValid(o_valid),
    .oBusy (o_busy),
    .oDone (o_done),
    .oOnes (o_ones)
  );

  function automatic logic [BW-1:0] brev(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    for (int j = 0; j < int'(BW); j++) r[j] = v[BW-1-j];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the whole expected window for an operand.
  task automatic push_window(input logic [BW-1:0] op);
    logic [BW-1:0] ones;
    logic          b;
    ones = '0;
    for (int i = 0; i < int'(WIN); i++) begin
      b    = (op > brev(BW'(i)));
      ones = ones + BW'(b);
      exp_q.push_back('{b: b, ones: ones, last: (i == int'(WIN) - 1)});
    end
  endtask

  task automatic start_window(input logic do_load, input logic [BW-1:0] d, input logic [BW-1:0] op);
    data  = d;
    load  = do_load;
    start = 1'b1;
    step();
    load  = 1'b0;
    start = 1'b0;
    push_window(op);
    check("start_busy", o_busy, 1);
    check("start_valid", o_valid, 0);
  endtask

  // Wait (bounded) for the last bit, then check the DONE state one cycle on.
  task automatic finish_window(input string name, input logic [BW-1:0] req_ones);
    int c;
    c = 0;
    while (o_done !== 1'b1 && c < 1200) begin
      step();
      c++;
    end
    check({name, "_done"}, o_done, 1);
    check({name, "_ones_at_last"}, o_ones, req_ones);
    check({name, "_valid_at_last"}, o_valid, 1);
    step();
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_valid_after"}, o_valid, 0);
    check({name, "_done_hold"}, o_done, 1);
    check({name, "_busy_after"}, o_busy, 0);
    check({name, "_ones_hold"}, o_ones, req_ones);
    check({name, "_last_bit"}, o_bit, 0);
  endtask

  // Monitor: every valid stream bit is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_unexpected_valid: got valid with ones=%0d, expected no valid bit", o_ones);
        end else begin
          e = exp_q.pop_front();
          check("mon_bit", o_bit, e.b);
          check("mon_ones", o_ones, e.ones);
          check("mon_done", o_done, e.last);
          check("mon_busy", o_busy, !e.last);
        end
      end
    end
  end

  initial begin
    logic [BW-1:0] exp_ones;
    int            idx;
    int            c;

    rst = 1'b1; load = 1'b0; start = 1'b0; en = 1'b0; clr = 1'b0; data = '0;
    step();
    step();
    check("rst_bit", o_bit, 0);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ones", o_ones, 0);
    rst = 1'b0;

    // Operand 128: alternating 1,0,1,0...
    data = 8'd128; load = 1'b1;
    step();
    load = 1'b0;
    start_window(1'b0, 8'd0, 8'd128);
    en = 1'b1;
    step();
    check("t1_first_valid", o_valid, 1);
    check("t1_bit0", o_bit, 1);
    step();
    check("t1_bit1", o_bit, 0);
    step();
    check("t1_bit2", o_bit, 1);
    finish_window("t1", 8'd128);

    // Boundary operands, load and start in the same cycle.
    start_window(1'b1, 8'd0, 8'd0);
    finish_window("t2_zero", 8'd0);
    start_window(1'b1, 8'd255, 8'd255);
    finish_window("t2_full", 8'd255);

    // Operand 134 with iEn toggling; outputs hold on paused edges.
    en = 1'b0;
    start_window(1'b1, 8'd134, 8'd134);
    exp_ones = '0;
    idx = 0;
    c = 0;
    while (o_done !== 1'b1 && c < 1200) begin
      en = ((c % 2) == 0);
      step();
      c++;
      if (en) begin
        exp_ones = exp_ones + BW'(8'd134 > brev(BW'(idx)));
        idx++;
      end else begin
        check("t3_pause_valid", o_valid, 0);
        check("t3_pause_ones", o_ones, exp_ones);
      end
    end
    check("t3_bits_emitted", idx, WIN);
    en = 1'b1;
    finish_window("t3", 8'd134);

    // Load/start mid-window are ignored.
    start_window(1'b0, 8'd0, 8'd134);
    repeat (100) step();
    data = 8'd10; load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    check("t4_still_busy", o_busy, 1);
    finish_window("t4", 8'd134);

    // Clear mid-window, then replay retained operand.
    start_window(1'b0, 8'd0, 8'd134);
    repeat (50) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_q.delete();
    check("t5_busy", o_busy, 0);
    check("t5_valid", o_valid, 0);
    check("t5_ones", o_ones, 0);
    check("t5_done", o_done, 0);
    start_window(1'b0, 8'd0, 8'd134);
    finish_window("t5", 8'd134);

    // Reset mid-window clears the operand as well.
    start_window(1'b0, 8'd0, 8'd134);
    repeat (70) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("t6_bit", o_bit, 0);
    check("t6_valid", o_valid, 0);
    check("t6_busy", o_busy, 0);
    check("t6_done", o_done, 0);
    check("t6_ones", o_ones, 0);
    start_window(1'b0, 8'd77, 8'd0);
    finish_window("t6", 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
